coherence_arbiter: RTL and testbench

COHERENCE_ARBITER -- requirements
Module: coherence_arbiter

---
 rtl/coherence_arbiter.sv | 174 +++++++++++++++++
 tb/tb_coherence_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_arbiter.sv
// ---------------------------------------------------------------------------
// coherence_arbiter
//
// Round-robin arbiter that funnels per-cache requests onto one memory port.
// Each request is read or write. A write that completes while more than one
// cache is present is followed by a single invalidate cycle. That cycle
// strobes every cache except the writer.
//
// Ports
//   clock                 single clock for all logic
//   reset                 synchronous, active-high reset
//   cache_request         packed per-channel {write, address, data}; channel i
//                         occupies slice i
//   cache_request_ready   per-channel request valid, held until acked
//   memory_ready          memory accepts memory_request this cycle
//   cache_request_ack     one-cycle one-hot grant pulse
//   memory_request        latched winning request
//   memory_request_ready  memory_request valid
//   grant_id              index of current/last winner
//   invalidate_address    address to invalidate, shared by all channels
//   invalidate_valid      per-channel invalidate strobe
// ---------------------------------------------------------------------------
module coherence_arbiter #(
    parameter int NUM_CACHES = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_CACHES*(1+ADDR_WIDTH+DATA_WIDTH)-1:0] cache_request,
    input  logic [NUM_CACHES-1:0]                           cache_request_ready,
    input  logic                                            memory_ready,
    output logic [NUM_CACHES-1:0]                           cache_request_ack,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]                  memory_request,
    output logic                                            memory_request_ready,
    output logic [((NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1)-1:0] grant_id,
    output logic [ADDR_WIDTH-1:0]                           invalidate_address,
    output logic [NUM_CACHES-1:0]                           invalidate_valid
);

    localparam int REQ_WIDTH   = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int GRANT_WIDTH = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, INVALIDATE} state_t;

    state_t                   state_reg,       state_next;
    logic [GRANT_WIDTH-1:0]   last_winner_reg, last_winner_next;
    logic [GRANT_WIDTH-1:0]   grant_id_reg,    grant_id_next;
    logic [REQ_WIDTH-1:0]     request_reg,     request_next;
    logic [NUM_CACHES-1:0]    ack_reg,         ack_next;
    logic                     issue_valid_reg, issue_valid_next;
    logic [ADDR_WIDTH-1:0]    inv_addr_reg,    inv_addr_next;
    logic [NUM_CACHES-1:0]    inv_valid_reg,   inv_valid_next;

    logic [REQ_WIDTH-1:0]     request_array [NUM_CACHES];
    logic [NUM_CACHES-1:0]    above_last;     // channels strictly after last winner
    logic [NUM_CACHES-1:0]    winner_onehot;
    logic [NUM_CACHES-1:0]    others_mask;    // every channel except the current grant
    logic [GRANT_WIDTH-1:0]   winner_hi, winner_any, winner;
    logic                     found_hi, found_any;
    logic [REQ_WIDTH-1:0]     selected_request;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CACHES; gi++) begin : g_chan
            assign request_array[gi] = cache_request[gi*REQ_WIDTH +: REQ_WIDTH];
            assign above_last[gi]    = (gi > int'(last_winner_reg));
            assign winner_onehot[gi] = (winner == GRANT_WIDTH'(gi));
            assign others_mask[gi]   = (grant_id_reg != GRANT_WIDTH'(gi));
        end
    endgenerate

    // Round robin as two priority encoders. Prefer the lowest requester above
    // the last winner. Otherwise wrap to the lowest requester overall. The
    // loop runs downward, so the lowest index is the last one written.
    always_comb begin
        found_hi   = 1'b0;
        winner_hi  = '0;
        winner_any = '0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (cache_request_ready[i]) begin
                winner_any = GRANT_WIDTH'(i);
                if (above_last[i]) begin
                    winner_hi = GRANT_WIDTH'(i);
                    found_hi  = 1'b1;
                end
            end
        end
        found_any = |cache_request_ready;
        winner    = found_hi ? winner_hi : winner_any;
    end

    always_comb begin
        selected_request = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (winner_onehot[i]) begin
                selected_request = request_array[i];
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_winner_next = last_winner_reg;
        grant_id_next    = grant_id_reg;
        request_next     = request_reg;
        ack_next         = '0;
        issue_valid_next = issue_valid_reg;
        inv_addr_next    = '0;
        inv_valid_next   = '0;
        case (state_reg)
            IDLE: begin
                issue_valid_next = 1'b0;
                if (found_any) begin
                    state_next       = ISSUE;
                    request_next     = selected_request;
                    last_winner_next = winner;
                    grant_id_next    = winner;
                    ack_next         = winner_onehot;
                    issue_valid_next = 1'b1;
                end
            end
            ISSUE: begin
                if (memory_ready) begin
                    issue_valid_next = 1'b0;
                    if (request_reg[REQ_WIDTH-1] && (NUM_CACHES > 1)) begin
                        state_next     = INVALIDATE;
                        inv_addr_next  = request_reg[REQ_WIDTH-2 -: ADDR_WIDTH];
                        inv_valid_next = others_mask;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            INVALIDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            // Initialise to the top channel so that channel 0 wins first.
            last_winner_reg <= GRANT_WIDTH'(NUM_CACHES - 1);
            grant_id_reg    <= '0;
            request_reg     <= '0;
            ack_reg         <= '0;
            issue_valid_reg <= 1'b0;
            inv_addr_reg    <= '0;
            inv_valid_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            last_winner_reg <= last_winner_next;
            grant_id_reg    <= grant_id_next;
            request_reg     <= request_next;
            ack_reg         <= ack_next;
            issue_valid_reg <= issue_valid_next;
            inv_addr_reg    <= inv_addr_next;
            inv_valid_reg   <= inv_valid_next;
        end
    end

    assign cache_request_ack    = ack_reg;
    assign memory_request       = request_reg;
    assign memory_request_ready = issue_valid_reg;
    assign grant_id             = grant_id_reg;
    assign invalidate_address   = inv_addr_reg;
    assign invalidate_valid     = inv_valid_reg;

endmodule

// File: tb/tb_coherence_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coherence_arbiter
//
// Bench for coherence_arbiter. It drives a two-channel instance and a
// four-channel instance with directed vectors. Expected grants and
// invalidates are queued when the stimulus is issued. One monitor per
// instance pops and compares an entry each time the DUT shows an ack pulse or
// an invalidate strobe.
// ---------------------------------------------------------------------------
module tb_coherence_arbiter;

    localparam int RW = 25;

    typedef struct {
        bit              is_inv;
        int              id;
        logic [RW-1:0]   data;
        logic [3:0]      mask;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // two-channel instance
    logic            reset2;
    logic [2*RW-1:0] req2;
    logic [1:0]      rdy2;
    logic            mr2;
    logic [1:0]      ack2;
    logic [RW-1:0]   mreq2;
    logic            mrr2;
    logic [0:0]      gid2;
    logic [15:0]     iaddr2;
    logic [1:0]      inv2;

    // four-channel instance
    logic            reset4;
    logic [4*RW-1:0] req4;
    logic [3:0]      rdy4;
    logic            mr4;
    logic [3:0]      ack4;
    logic [RW-1:0]   mreq4;
    logic            mrr4;
    logic [1:0]      gid4;
    logic [15:0]     iaddr4;
    logic [3:0]      inv4;

    coherence_arbiter #(.NUM_CACHES(2), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut2 (
        .clock                (clock),
        .reset                (reset2),
        .cache_request        (req2),
        .cache_request_ready  (rdy2),
        .memory_ready         (mr2),
        .cache_request_ack    (ack2),
        .memory_request       (mreq2),
        .memory_request_ready (mrr2),
        .grant_id             (gid2),
        .invalidate_address   (iaddr2),
        .invalidate_valid     (inv2)
    );

    coherence_arbiter #(.NUM_CACHES(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut4 (
        .clock                (clock),
        .reset                (reset4),
        .cache_request        (req4),
        .cache_request_ready  (rdy4),
        .memory_ready         (mr4),
        .cache_request_ack    (ack4),
        .memory_request       (mreq4),
        .memory_request_ready (mrr4),
        .grant_id             (gid4),
        .invalidate_address   (iaddr4),
        .invalidate_valid     (inv4)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q2[$];
    exp_t q4[$];
    int   last_len2   = 0;
    int   g4_count    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [RW-1:0] mk(input bit w, input logic [15:0] a, input logic [7:0] d);
        return {w, a, d};
    endfunction

    task automatic push_g(input bit four, input int id, input logic [RW-1:0] d);
        exp_t e;
        e.is_inv = 1'b0; e.id = id; e.data = d; e.mask = 4'h0;
        if (four) q4.push_back(e); else q2.push_back(e);
    endtask

    task automatic push_i(input bit four, input logic [3:0] mask, input logic [15:0] a);
        exp_t e;
        e.is_inv = 1'b1; e.id = 0; e.data = RW'(a); e.mask = mask;
        if (four) q4.push_back(e); else q2.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_ack2(input logic [1:0] m);
        int n = 0;
        while ((ack2 & m) == 2'b00 && n < 20) begin
            step(1);
            n++;
        end
        chk("ack2_wait", 32'(ack2 & m), 32'(m));
    endtask

    task automatic drain(input bit four, input string name);
        step(12);
        if (four) chk(name, 32'(q4.size()), 32'd0);
        else      chk(name, 32'(q2.size()), 32'd0);
    endtask

    // A requester lowers its valid as soon as it sees its ack.
    always @(posedge clock) begin
        #1;
        rdy2 = rdy2 & ~ack2;
    end

    // ---------------- monitor, two-channel instance ----------------
    int            run2      = 0;
    logic          prev_mrr2 = 1'b0;
    logic [RW-1:0] prev_mreq2 = '0;

    always @(negedge clock) begin : mon2
        exp_t e;
        if (reset2) begin
            run2      = 0;
            prev_mrr2 = 1'b0;
        end else begin
            if (ack2 != 2'b00) begin
                if (q2.size() == 0) begin
                    chk("grant2_unexpected", 32'(ack2), 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("grant2_kind",  32'd0, 32'(e.is_inv));
                    chk("grant2_ack",   32'(ack2), 32'd1 << e.id);
                    chk("grant2_id",    32'(gid2), 32'(e.id));
                    chk("grant2_req",   32'(mreq2), 32'(e.data));
                    chk("grant2_ready", 32'(mrr2), 32'd1);
                end
            end
            if (inv2 != 2'b00) begin
                if (q2.size() == 0) begin
                    chk("inv2_unexpected", 32'(inv2), 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("inv2_kind", 32'd1, 32'(e.is_inv));
                    chk("inv2_mask", 32'(inv2), 32'(e.mask[1:0]));
                    chk("inv2_addr", 32'(iaddr2), 32'(e.data[15:0]));
                end
            end
            if (mrr2 && prev_mrr2 && ack2 == 2'b00)
                chk("mreq2_stable", 32'(mreq2), 32'(prev_mreq2));
            if (mrr2) begin
                run2++;
            end else if (run2 != 0) begin
                last_len2 = run2;
                run2      = 0;
            end
            prev_mrr2  = mrr2;
            prev_mreq2 = mreq2;
        end
    end

    // ---------------- monitor, four-channel instance ----------------
    always @(negedge clock) begin : mon4
        exp_t e;
        if (!reset4) begin
            if (ack4 != 4'h0) begin
                g4_count++;
                if (q4.size() == 0) begin
                    chk("grant4_unexpected", 32'(ack4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("grant4_kind", 32'd0, 32'(e.is_inv));
                    chk("grant4_ack",  32'(ack4), 32'd1 << e.id);
                    chk("grant4_id",   32'(gid4), 32'(e.id));
                    chk("grant4_req",  32'(mreq4), 32'(e.data));
                end
            end
            if (inv4 != 4'h0) begin
                if (q4.size() == 0) begin
                    chk("inv4_unexpected", 32'(inv4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("inv4_kind", 32'd1, 32'(e.is_inv));
                    chk("inv4_mask", 32'(inv4), 32'(e.mask));
                    chk("inv4_addr", 32'(iaddr4), 32'(e.data[15:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset2 = 1'b1; reset4 = 1'b1;
        req2 = '0; rdy2 = '0; mr2 = 1'b0;
        req4 = '0; rdy4 = '0; mr4 = 1'b0;
        step(3);

        // reset state
        chk("rst2_ack",   32'(ack2),   32'd0);
        chk("rst2_ready", 32'(mrr2),   32'd0);
        chk("rst2_gid",   32'(gid2),   32'd0);
        chk("rst2_mreq",  32'(mreq2),  32'd0);
        chk("rst2_inv",   32'(inv2),   32'd0);
        chk("rst2_iaddr", 32'(iaddr2), 32'd0);
        chk("rst4_ack",   32'(ack4),   32'd0);
        chk("rst4_inv",   32'(inv4),   32'd0);
        reset2 = 1'b0;
        step(1);

        // single read on channel 0, memory ready at once
        req2[0 +: RW] = mk(1'b0, 16'h1234, 8'h5A);
        mr2 = 1'b1;
        push_g(1'b0, 0, mk(1'b0, 16'h1234, 8'h5A));
        rdy2[0] = 1'b1;
        wait_ack2(2'b01);
        drain(1'b0, "read_drain");
        chk("read_ready_len", 32'(last_len2), 32'd1);

        // simultaneous writes from reset: ch0 first, then ch1
        reset2 = 1'b1; step(1); reset2 = 1'b0;
        req2 = {mk(1'b1, 16'h00B0, 8'h22), mk(1'b1, 16'h00A0, 8'h11)};
        push_g(1'b0, 0, mk(1'b1, 16'h00A0, 8'h11));
        push_i(1'b0, 4'b0010, 16'h00A0);
        push_g(1'b0, 1, mk(1'b1, 16'h00B0, 8'h22));
        push_i(1'b0, 4'b0001, 16'h00B0);
        rdy2 = 2'b11;
        drain(1'b0, "dual_write_drain");

        // memory stalls five cycles in ISSUE
        req2[RW +: RW] = mk(1'b0, 16'h4321, 8'h33);
        mr2 = 1'b0;
        push_g(1'b0, 1, mk(1'b0, 16'h4321, 8'h33));
        rdy2[1] = 1'b1;
        wait_ack2(2'b10);
        step(5);
        mr2 = 1'b1;
        drain(1'b0, "stall_drain");
        chk("stall_ready_len", 32'(last_len2), 32'd6);

        // reset during ISSUE of a write
        reset2 = 1'b1; step(1); reset2 = 1'b0;
        req2[RW +: RW] = mk(1'b1, 16'h0777, 8'h44);
        mr2 = 1'b0;
        push_g(1'b0, 1, mk(1'b1, 16'h0777, 8'h44));
        rdy2[1] = 1'b1;
        wait_ack2(2'b10);
        step(1);
        reset2 = 1'b1;
        step(1);
        chk("midrst_ack",   32'(ack2),  32'd0);
        chk("midrst_ready", 32'(mrr2),  32'd0);
        chk("midrst_gid",   32'(gid2),  32'd0);
        chk("midrst_mreq",  32'(mreq2), 32'd0);
        chk("midrst_inv",   32'(inv2),  32'd0);
        reset2 = 1'b0;
        mr2 = 1'b1;
        step(4);
        req2 = {mk(1'b0, 16'h0200, 8'h02), mk(1'b0, 16'h0100, 8'h01)};
        push_g(1'b0, 0, mk(1'b0, 16'h0100, 8'h01));
        push_g(1'b0, 1, mk(1'b0, 16'h0200, 8'h02));
        rdy2 = 2'b11;
        drain(1'b0, "post_reset_drain");

        // ch1 drops valid and changes its request after the grant; ch0 then writes
        req2[RW +: RW] = mk(1'b1, 16'h0BBB, 8'h55);
        mr2 = 1'b0;
        push_g(1'b0, 1, mk(1'b1, 16'h0BBB, 8'h55));
        push_i(1'b0, 4'b0001, 16'h0BBB);
        rdy2[1] = 1'b1;
        wait_ack2(2'b10);
        req2[RW +: RW] = mk(1'b0, 16'hFFFF, 8'hFF);
        req2[0 +: RW]  = mk(1'b1, 16'h0AAA, 8'h66);
        push_g(1'b0, 0, mk(1'b1, 16'h0AAA, 8'h66));
        push_i(1'b0, 4'b0010, 16'h0AAA);
        rdy2[0] = 1'b1;
        step(2);
        mr2 = 1'b1;
        drain(1'b0, "latch_drain");

        // four channels requesting continuously: order 0,1,2,3,0
        reset4 = 1'b0;
        for (int i = 0; i < 4; i++)
            req4[i*RW +: RW] = mk(1'b1, 16'h0C00 + 16'(i), 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            push_g(1'b1, k % 4, mk(1'b1, 16'h0C00 + 16'(k % 4), 8'h10 + 8'(k % 4)));
            push_i(1'b1, 4'hF & ~(4'h1 << (k % 4)), 16'h0C00 + 16'(k % 4));
        end
        mr4 = 1'b1;
        rdy4 = 4'hF;
        n = 0;
        while (g4_count < 5 && n < 60) begin
            step(1);
            n++;
        end
        rdy4 = 4'h0;
        drain(1'b1, "rr4_drain");
        chk("rr4_grants", 32'(g4_count), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
